instr_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the 32-bit CPU datapath.
- Owns the PC and an 8-entry register file.
- Fetches instructions from the RAM block (registered read, 1-cycle latency) and drives the combinational ALU and Cond blocks.
- Consumes their results to perform writeback, load/store and branch resolution.

---
 rtl/instr_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns PC, 8x32 register file, drives RAM/ALU/Cond.
// Optional INSTR_SEQ_PERF_EN adds retired_cnt, a count of completed instructions.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          R0_ZERO  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        mem_load,
    output logic        mem_save,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_panic,
    output logic [31:0] cond_a,
    output logic [31:0] cond_b,
    output logic [2:0]  cond_op,
    input  logic        cond_out,
    output logic [31:0] pc_out,
    output logic        carry_flag,
    output logic        halted,
    output logic        fault
`ifdef INSTR_SEQ_PERF_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        carry_q, carry_d;
    logic [31:0] regs_q [8];
    logic        wr_en;
    logic [31:0] wr_data;

    logic [3:0]  cls;
    logic [2:0]  sub, rd, rs1, rs2;
    logic [31:0] simm, rs1_val, rs2_val, pc_inc, pc_br;
    state_t      after_retire;

    assign cls  = ir_q[31:28];
    assign sub  = ir_q[27:25];
    assign rd   = ir_q[24:22];
    assign rs1  = ir_q[21:19];
    assign rs2  = ir_q[18:16];
    assign simm = {{16{ir_q[15]}}, ir_q[15:0]};

    assign rs1_val = (R0_ZERO && rs1 == 3'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val = (R0_ZERO && rs2 == 3'd0) ? 32'd0 : regs_q[rs2];
    // Branch target uses its own adder so the ALU stays free for the condition-less path.
    assign pc_inc  = pc_q + 32'd1;
    assign pc_br   = pc_q + simm;
    assign after_retire = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        carry_d   = carry_q;
        wr_en     = 1'b0;
        wr_data   = alu_result;
        mem_load  = 1'b0;
        mem_save  = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_op    = 3'd0;
        cond_a    = 32'd0;
        cond_b    = 32'd0;
        cond_op   = 3'd0;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                mem_load = 1'b1;
                mem_addr = pc_q;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    4'd0, 4'd1: begin
                        alu_a  = rs1_val;
                        alu_b  = (cls == 4'd0) ? rs2_val : simm;
                        alu_op = sub;
                        if (alu_panic) begin
                            state_d = S_FAULT;
                        end else begin
                            wr_en   = 1'b1;
                            carry_d = alu_carry;
                            pc_d    = pc_inc;
                            state_d = after_retire;
                        end
                    end
                    4'd2: begin
                        alu_a    = rs1_val;
                        alu_b    = simm;
                        mem_load = 1'b1;
                        mem_addr = alu_result;
                        state_d  = S_MEM;
                    end
                    4'd3: begin
                        alu_a     = rs1_val;
                        alu_b     = simm;
                        mem_save  = 1'b1;
                        mem_addr  = alu_result;
                        mem_wdata = rs2_val;
                        pc_d      = pc_inc;
                        state_d   = after_retire;
                    end
                    4'd4: begin
                        cond_a  = rs1_val;
                        cond_b  = rs2_val;
                        cond_op = sub;
                        pc_d    = cond_out ? pc_br : pc_inc;
                        state_d = after_retire;
                    end
                    4'd5:    state_d = S_HALT;
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                wr_en   = 1'b1;
                wr_data = mem_rdata;
                pc_d    = pc_inc;
                state_d = after_retire;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            carry_q <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
            if (wr_en && !(R0_ZERO && rd == 3'd0)) regs_q[rd] <= wr_data;
        end
    end

    assign pc_out     = pc_q;
    assign carry_flag = carry_q;
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);

`ifdef INSTR_SEQ_PERF_EN
    logic        retire;
    logic [31:0] retired_q;

    assign retire = (state_q == S_MEM) ||
                    (state_q == S_EXEC && (((cls == 4'd0 || cls == 4'd1) && !alu_panic) ||
                                           cls == 4'd3 || cls == 4'd4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired_q <= 32'd0;
        else if (retire) retired_q <= retired_q + 32'd1;
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with behavioural RAM, ALU and Cond models.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run;
    logic        mem_load, mem_save;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op, cond_op;
    logic        alu_carry, alu_panic;
    logic [31:0] cond_a, cond_b;
    logic        cond_out;
    logic [31:0] pc_out;
    logic        carry_flag, halted, fault;
`ifdef INSTR_SEQ_PERF_EN
    logic [31:0] retired_cnt;
`endif

    int vec  = 0;
    int errs = 0;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_load(mem_load), .mem_save(mem_save), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_panic(alu_panic),
        .cond_a(cond_a), .cond_b(cond_b), .cond_op(cond_op), .cond_out(cond_out),
        .pc_out(pc_out), .carry_flag(carry_flag), .halted(halted), .fault(fault)
`ifdef INSTR_SEQ_PERF_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    // RAM with registered read
    always @(posedge clk) begin
        if (mem_save) mem[int'(mem_addr & 32'hFF)] = mem_wdata;
        if (mem_load) mem_rdata <= mem[int'(mem_addr & 32'hFF)];
    end

    always_comb begin
        alu_result = 32'd0;
        alu_carry  = 1'b0;
        alu_panic  = 1'b0;
        case (alu_op)
            3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            default: alu_panic = 1'b1;
        endcase
    end

    always_comb begin
        case (cond_op)
            3'd0:    cond_out = (cond_a == cond_b);
            3'd1:    cond_out = (cond_a != cond_b);
            3'd3:    cond_out = ($signed(cond_a) < $signed(cond_b));
            default: cond_out = 1'b0;
        endcase
    end

    function automatic logic [31:0] enc(input int cls, input int sub, input int rd,
                                        input int rs1, input int rs2, input int imm);
        return {cls[3:0], sub[2:0], rd[2:0], rs1[2:0], rs2[2:0], imm[15:0]};
    endfunction

    localparam logic [31:0] HALT_W = 32'h5000_0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    endtask

    task automatic fill_nops(input int upto);
        for (int i = 0; i < upto; i++) mem[i] = enc(1, 0, 5, 5, 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_pc(input logic [31:0] target, input string name);
        int n = 0;
        while (pc_out !== target && n < 200) begin
            tick();
            n++;
        end
        vec++;
        if (pc_out !== target) begin
            errs++;
            $display("FAIL %s: pc=%h, expected %h within 200 cycles", name, pc_out, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        #2;
        vec++;
        if (pc_out !== 32'd0 || carry_flag !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
            errs++;
            $display("FAIL reset_state: pc=%h carry=%b halted=%b fault=%b, expected 0/0/0/0",
                     pc_out, carry_flag, halted, fault);
        end
        vec++;
        if (mem_load !== 1'b0 || mem_save !== 1'b0 || mem_addr !== 32'd0 || alu_op !== 3'd0) begin
            errs++;
            $display("FAIL reset_strobes: load=%b save=%b addr=%h aluop=%0d, expected all 0",
                     mem_load, mem_save, mem_addr, alu_op);
        end
    endtask

    task automatic test_alu_ri();
        clear_mem();
        mem[0] = 32'h1040_0005;
        mem[1] = enc(3, 0, 0, 0, 1, 100);
        do_reset();
        run = 1'b1;
        tick();
        vec++;
        if (mem_load !== 1'b1 || mem_addr !== 32'd0) begin
            errs++;
            $display("FAIL fetch0: load=%b addr=%h, expected 1/00000000", mem_load, mem_addr);
        end
        tick();
        tick();
        vec++;
        if (pc_out !== 32'd0) begin
            errs++;
            $display("FAIL exec_pc_hold: pc=%h, expected 0", pc_out);
        end
        tick();
        vec++;
        if (pc_out !== 32'd1 || carry_flag !== 1'b0) begin
            errs++;
            $display("FAIL addi_retire: pc=%h carry=%b, expected 1/0", pc_out, carry_flag);
        end
        wait_pc(2, "addi_store_done");
        vec++;
        if (mem[100] !== 32'd5) begin
            errs++;
            $display("FAIL addi_r1: R1=%h, expected 00000005", mem[100]);
        end
    endtask

    task automatic test_carry();
        clear_mem();
        mem[0] = enc(1, 0, 1, 0, 0, -1);
        mem[1] = enc(1, 0, 2, 0, 0, 1);
        mem[2] = enc(0, 0, 3, 1, 2, 0);
        mem[3] = enc(3, 0, 0, 0, 3, 101);
        mem[4] = enc(0, 0, 0, 1, 2, 0);
        mem[5] = enc(3, 0, 0, 0, 0, 102);
        mem[101] = 32'h5555_5555;
        mem[102] = 32'hAAAA_AAAA;
        do_reset();
        run = 1'b1;
        wait_pc(2, "carry_pre");
        vec++;
        if (carry_flag !== 1'b0) begin
            errs++;
            $display("FAIL carry_clear: carry=%b, expected 0", carry_flag);
        end
        wait_pc(3, "carry_add");
        vec++;
        if (carry_flag !== 1'b1) begin
            errs++;
            $display("FAIL carry_set: carry=%b, expected 1", carry_flag);
        end
        wait_pc(6, "carry_r0");
        vec++;
        if (mem[101] !== 32'd0 || mem[102] !== 32'd0 || carry_flag !== 1'b1) begin
            errs++;
            $display("FAIL add_wrap: R3=%h R0=%h carry=%b, expected 0/0/1",
                     mem[101], mem[102], carry_flag);
        end
    endtask

    task automatic test_store_load();
        int n;
        clear_mem();
        mem[0] = enc(1, 0, 1, 0, 0, 16);
        mem[1] = enc(2, 0, 2, 0, 0, 103);
        mem[2] = enc(3, 0, 0, 1, 2, -1);
        mem[3] = enc(2, 0, 4, 1, 0, -1);
        mem[4] = enc(3, 0, 0, 0, 4, 104);
        mem[15]  = 32'd0;
        mem[103] = 32'hDEAD_BEEF;
        mem[104] = 32'd0;
        do_reset();
        run = 1'b1;
        wait_pc(2, "store_reach");
        tick();
        vec++;
        if (mem_save !== 1'b0) begin
            errs++;
            $display("FAIL store_decode: save=%b, expected 0", mem_save);
        end
        tick();
        vec++;
        if (mem_save !== 1'b1 || mem_addr !== 32'd15 || mem_wdata !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL store_exec: save=%b addr=%h wdata=%h, expected 1/0000000f/deadbeef",
                     mem_save, mem_addr, mem_wdata);
        end
        tick();
        vec++;
        if (mem_save !== 1'b0 || pc_out !== 32'd3 || mem[15] !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL store_after: save=%b pc=%h mem15=%h, expected 0/3/deadbeef",
                     mem_save, pc_out, mem[15]);
        end
        n = 0;
        while (pc_out === 32'd3 && n < 20) begin
            tick();
            n++;
        end
        vec++;
        if (n != 4 || pc_out !== 32'd4) begin
            errs++;
            $display("FAIL load_latency: %0d cycles to pc=%h, expected 4 cycles to 4", n, pc_out);
        end
        wait_pc(5, "load_dump");
        vec++;
        if (mem[104] !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL load_r4: R4=%h, expected deadbeef", mem[104]);
        end
    endtask

    task automatic test_branch();
        int r1v [2] = '{-1, 1};
        logic [31:0] exp_pc [2] = '{32'd6, 32'd11};
        for (int k = 0; k < 2; k++) begin
            clear_mem();
            fill_nops(10);
            mem[0]  = enc(1, 0, 1, 0, 0, r1v[k]);
            mem[1]  = enc(1, 0, 2, 0, 0, 0);
            mem[10] = enc(4, 3, 0, 1, 2, -4);
            do_reset();
            run = 1'b1;
            wait_pc(10, "branch_reach");
            tick();
            tick();
            tick();
            vec++;
            if (pc_out !== exp_pc[k]) begin
                errs++;
                $display("FAIL branch_lt%0d: pc=%h, expected %h", k, pc_out, exp_pc[k]);
            end
        end
    endtask

    task automatic test_illegal();
        logic strobed;
        clear_mem();
        fill_nops(7);
        mem[7] = 32'hF000_0000;
        do_reset();
        run = 1'b1;
        wait_pc(7, "illegal_reach");
        tick();
        tick();
        tick();
        vec++;
        if (fault !== 1'b1 || halted !== 1'b0 || pc_out !== 32'd7) begin
            errs++;
            $display("FAIL illegal_fault: fault=%b halted=%b pc=%h, expected 1/0/7",
                     fault, halted, pc_out);
        end
        strobed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_load !== 1'b0 || mem_save !== 1'b0 || fault !== 1'b1) strobed = 1'b1;
        end
        vec++;
        if (strobed !== 1'b0 || pc_out !== 32'd7) begin
            errs++;
            $display("FAIL fault_sticky: activity=%b pc=%h, expected 0/7", strobed, pc_out);
        end
        clear_mem();
        mem[0] = enc(0, 7, 1, 0, 0, 0);
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vec++;
        if (fault !== 1'b1 || pc_out !== 32'd0) begin
            errs++;
            $display("FAIL alu_panic: fault=%b pc=%h, expected 1/0", fault, pc_out);
        end
    endtask

    task automatic test_halt();
        logic strobed;
        clear_mem();
        fill_nops(3);
        do_reset();
        run = 1'b1;
        wait_pc(3, "halt_reach");
        tick();
        tick();
        tick();
        vec++;
        if (halted !== 1'b1 || fault !== 1'b0 || pc_out !== 32'd3) begin
            errs++;
            $display("FAIL halt_state: halted=%b fault=%b pc=%h, expected 1/0/3",
                     halted, fault, pc_out);
        end
        strobed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_load !== 1'b0 || halted !== 1'b1) strobed = 1'b1;
        end
        vec++;
        if (strobed !== 1'b0 || pc_out !== 32'd3) begin
            errs++;
            $display("FAIL halt_sticky: activity=%b pc=%h, expected 0/3", strobed, pc_out);
        end
    endtask

    task automatic test_reset_mid_store();
        clear_mem();
        mem[0]  = enc(1, 0, 1, 0, 0, 7);
        mem[1]  = enc(3, 0, 0, 0, 1, 50);
        mem[50] = 32'd0;
        do_reset();
        run = 1'b1;
        wait_pc(1, "rst_store_reach");
        tick();
        tick();
        vec++;
        if (mem_save !== 1'b1) begin
            errs++;
            $display("FAIL rst_store_pre: save=%b, expected 1", mem_save);
        end
        rst_n = 1'b0;
        #1;
        vec++;
        if (mem_save !== 1'b0 || pc_out !== 32'd0) begin
            errs++;
            $display("FAIL rst_store_drop: save=%b pc=%h, expected 0/0", mem_save, pc_out);
        end
        tick();
        vec++;
        if (mem[50] !== 32'd0) begin
            errs++;
            $display("FAIL rst_store_nowrite: mem50=%h, expected 0", mem[50]);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_run_pause();
        logic strobed;
        clear_mem();
        mem[0] = enc(1, 0, 1, 0, 0, 1);
        mem[1] = enc(1, 0, 2, 0, 0, 2);
        do_reset();
        run = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        vec++;
        if (pc_out !== 32'd1 || mem_load !== 1'b0) begin
            errs++;
            $display("FAIL pause_idle: pc=%h load=%b, expected 1/0", pc_out, mem_load);
        end
        strobed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mem_load !== 1'b0) strobed = 1'b1;
        end
        vec++;
        if (strobed !== 1'b0 || pc_out !== 32'd1) begin
            errs++;
            $display("FAIL pause_hold: load_seen=%b pc=%h, expected 0/1", strobed, pc_out);
        end
        run = 1'b1;
        tick();
        vec++;
        if (mem_load !== 1'b1 || mem_addr !== 32'd1) begin
            errs++;
            $display("FAIL resume_fetch: load=%b addr=%h, expected 1/1", mem_load, mem_addr);
        end
    endtask

`ifdef INSTR_SEQ_PERF_EN
    task automatic test_perf();
        clear_mem();
        fill_nops(5);
        do_reset();
        run = 1'b1;
        vec++;
        if (retired_cnt !== 32'd0) begin
            errs++;
            $display("FAIL perf_reset: cnt=%0d, expected 0", retired_cnt);
        end
        wait_pc(5, "perf_reach");
        for (int i = 0; i < 8; i++) tick();
        vec++;
        if (retired_cnt !== 32'd5 || halted !== 1'b1) begin
            errs++;
            $display("FAIL perf_count: cnt=%0d halted=%b, expected 5/1", retired_cnt, halted);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_ri();
        test_carry();
        test_store_load();
        test_branch();
        test_illegal();
        test_halt();
        test_reset_mid_store();
        test_run_pause();
`ifdef INSTR_SEQ_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
